// File: rtl/sel_seq.sv
// rtl/sel_seq.sv - three-phase select sequencer with serial MSB-first data output
module sel_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               ck,
    input  logic               res,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         data_in,
    output logic [1:0]         sel,
    output logic               fin,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [7:0]         shreg;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_r;

    always_ff @(posedge ck) begin
        if (!res) begin
            state   <= IDLE;
            sel     <= 2'b00;
            fin     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            dwell_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel  <= 2'b00;
                    fin  <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        fin     <= data_in[7];
                        shreg   <= {data_in[6:0], 1'b0};
                        dwell_r <= dwell;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    // Zero fill means fin naturally reads 0 once all 8 bits are out.
                    fin   <= shreg[7];
                    shreg <= {shreg[6:0], 1'b0};
                    if (cnt != dwell_r) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        cnt <= '0;
                        if (sel != 2'b10) begin
                            sel <= sel + 2'b01;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sel   <= 2'b00;
                            fin   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    sel   <= 2'b00;
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    sel   <= 2'b00;
                    fin   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sel_seq.sv
// tb/tb_sel_seq.sv - directed self-checking bench for sel_seq
module tb_sel_seq;

    logic       ck = 1'b0;
    logic       res;
    logic       start;
    logic [3:0] dwell;
    logic [7:0] data_in;
    logic [1:0] sel;
    logic       fin;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_bad = 0;
    int n_done = 0;

    sel_seq #(.DWELL_W(4)) dut (
        .ck      (ck),
        .res     (res),
        .start   (start),
        .dwell   (dwell),
        .data_in (data_in),
        .sel     (sel),
        .fin     (fin),
        .busy    (busy),
        .done    (done)
    );

    always #5 ck = ~ck;

    always @(posedge ck) begin
        #1;
        if (done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ck);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_sel, input logic e_fin,
                           input logic e_busy, input logic e_done);
        check({tag, "_sel"}, {30'd0, sel}, {30'd0, e_sel});
        check({tag, "_fin"}, {31'd0, fin}, {31'd0, e_fin});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
        check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    // dwell=2, data_in=F0: sel held 3 cycles per phase, first four fin bits high.
    task automatic run_f0(input bit scramble, input string tag);
        logic [1:0] sel_tab [9];
        logic       fin_tab [9];
        sel_tab = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        fin_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        n_done  = 0;
        start   = 1'b1;
        dwell   = 4'd2;
        data_in = 8'hF0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_out($sformatf("%s_c%0d", tag, i), sel_tab[i], fin_tab[i], 1'b1, 1'b0);
            if (scramble) begin
                dwell   = 4'($urandom);
                data_in = 8'($urandom);
                start   = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk_out({tag, "_done"}, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_out({tag, "_idle"}, 2'd0, 1'b0, 1'b0, 1'b0);
        check({tag, "_ndone"}, n_done, 1);
    endtask

    initial begin
        logic [7:0] d;
        res     = 1'b0;
        start   = 1'b1;
        dwell   = 4'd7;
        data_in = 8'hFF;
        tick();
        tick();
        chk_out("rst", 2'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk_out("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        res   = 1'b1;
        tick();
        chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // dwell=0, A5, with start re-pulsed during RUN and during DONE
        n_done  = 0;
        start   = 1'b1;
        dwell   = 4'd0;
        data_in = 8'hA5;
        tick();
        start = 1'b0;
        chk_out("a5_e1", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("a5_e2", 2'd1, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("a5_e3", 2'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("a5_e4", 2'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("a5_e5", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("a5_e6", 2'd0, 1'b0, 1'b0, 1'b0);
        check("a5_ndone", n_done, 1);

        run_f0(1'b0, "f0");
        run_f0(1'b1, "f0scr");

        // dwell all ones, 16 cycles per phase, 48 RUN cycles
        n_done  = 0;
        d       = 8'h96;
        start   = 1'b1;
        dwell   = 4'd15;
        data_in = d;
        tick();
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            check($sformatf("max_sel%0d", i), {30'd0, sel}, i / 16);
            check($sformatf("max_fin%0d", i), {31'd0, fin}, (i < 8) ? {31'd0, d[7-i]} : 32'd0);
            check($sformatf("max_busy%0d", i), {31'd0, busy}, 1);
            tick();
        end
        chk_out("max_done", 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("max_ndone", n_done, 1);

        // reset abort mid-run, then a fresh start
        n_done  = 0;
        start   = 1'b1;
        dwell   = 4'd2;
        data_in = 8'hF0;
        tick();
        start = 1'b0;
        chk_out("ab_e1", 2'd0, 1'b1, 1'b1, 1'b0);
        res = 1'b0;
        tick();
        res = 1'b1;
        chk_out("ab_e2", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ab_e3", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ab_e4", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        start   = 1'b1;
        dwell   = 4'd0;
        data_in = 8'h80;
        tick();
        start = 1'b0;
        chk_out("ab_e6", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("ab_e7", 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("ab_e8", 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("ab_e9", 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("ab_ndone", n_done, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
